// File: rtl/boid_frame_scheduler.sv
// Per-frame framebuffer update sequencer: on each screenEnd rising edge it erases every
// boid's previously drawn pixel, then reads each boid's new position and draws it.
module boid_frame_scheduler #(
  parameter int NUM_BOIDS           = 16,
  parameter int VIDEO_WIDTH         = 640,
  parameter int VIDEO_HEIGHT        = 480,
  parameter int PIXEL_ADDRESS_WIDTH = 20
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             screenEnd,
  input  logic                             enable,
  output logic [$clog2(NUM_BOIDS)-1:0]     pos_index,
  input  logic [9:0]                       pos_x,
  input  logic [8:0]                       pos_y,
  output logic                             fb_wr_en,
  output logic [PIXEL_ADDRESS_WIDTH-1:0]   fb_wr_addr,
  output logic                             fb_wr_data,
  output logic                             busy,
  output logic                             frame_done,
  output logic [7:0]                       overrun_count
);

  localparam int IDX_W = $clog2(NUM_BOIDS);
  localparam int AW    = PIXEL_ADDRESS_WIDTH;

  typedef enum logic [2:0] {IDLE, ERASE, DRAW_RD, DRAW_WR, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               screen_end_d_reg;
  logic [IDX_W-1:0]   pos_index_reg, pos_index_next;
  logic               fb_wr_en_reg, fb_wr_en_next;
  logic [AW-1:0]      fb_wr_addr_reg, fb_wr_addr_next;
  logic               fb_wr_data_reg, fb_wr_data_next;
  logic               busy_reg, busy_next;
  logic               frame_done_reg, frame_done_next;
  logic [7:0]         overrun_reg, overrun_next;

  logic               prev_valid_reg [NUM_BOIDS];
  logic [AW-1:0]      prev_addr_reg  [NUM_BOIDS];
  logic               prev_we;
  logic               prev_we_valid;

  logic               start;
  logic               last;
  logic               in_range;
  logic [AW-1:0]      draw_addr;

  assign start     = screenEnd & ~screen_end_d_reg;
  assign last      = (idx_reg == IDX_W'(NUM_BOIDS - 1));
  assign in_range  = (int'(pos_x) < VIDEO_WIDTH) && (int'(pos_y) < VIDEO_HEIGHT);
  assign draw_addr = AW'(pos_x) + AW'(pos_y) * AW'(VIDEO_WIDTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      screen_end_d_reg <= 1'b0;
      pos_index_reg    <= '0;
      fb_wr_en_reg     <= 1'b0;
      fb_wr_addr_reg   <= '0;
      fb_wr_data_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      frame_done_reg   <= 1'b0;
      overrun_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      screen_end_d_reg <= screenEnd;
      pos_index_reg    <= pos_index_next;
      fb_wr_en_reg     <= fb_wr_en_next;
      fb_wr_addr_reg   <= fb_wr_addr_next;
      fb_wr_data_reg   <= fb_wr_data_next;
      busy_reg         <= busy_next;
      frame_done_reg   <= frame_done_next;
      overrun_reg      <= overrun_next;
    end
  end

  // Per-boid record of the last pixel drawn, so the next frame knows what to erase.
  generate
    for (genvar gi = 0; gi < NUM_BOIDS; gi++) begin : g_prev
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prev_valid_reg[gi] <= 1'b0;
          prev_addr_reg[gi]  <= '0;
        end else if (prev_we && (idx_reg == IDX_W'(gi))) begin
          prev_valid_reg[gi] <= prev_we_valid;
          if (prev_we_valid) begin
            prev_addr_reg[gi] <= draw_addr;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    pos_index_next  = pos_index_reg;
    fb_wr_en_next   = 1'b0;
    fb_wr_addr_next = '0;
    fb_wr_data_next = 1'b0;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    overrun_next    = overrun_reg;
    prev_we         = 1'b0;
    prev_we_valid   = 1'b0;

    if (start && (state_reg != IDLE) && (overrun_reg != 8'hFF)) begin
      overrun_next = overrun_reg + 8'd1;
    end

    case (state_reg)
      IDLE: begin
        if (start && enable) begin
          state_next = ERASE;
          idx_next   = '0;
          busy_next  = 1'b1;
        end
      end
      ERASE: begin
        fb_wr_en_next   = prev_valid_reg[idx_reg];
        fb_wr_addr_next = prev_addr_reg[idx_reg];
        if (last) begin
          state_next     = DRAW_RD;
          idx_next       = '0;
          pos_index_next = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      // pos_index already holds idx here, so the position memory returns data in DRAW_WR.
      DRAW_RD: begin
        state_next = DRAW_WR;
      end
      DRAW_WR: begin
        prev_we = 1'b1;
        if (in_range) begin
          prev_we_valid   = 1'b1;
          fb_wr_en_next   = 1'b1;
          fb_wr_data_next = 1'b1;
          fb_wr_addr_next = draw_addr;
        end
        if (last) begin
          state_next      = DONE;
          idx_next        = '0;
          pos_index_next  = '0;
          frame_done_next = 1'b1;
        end else begin
          state_next     = DRAW_RD;
          idx_next       = idx_reg + 1'b1;
          pos_index_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pos_index     = pos_index_reg;
  assign fb_wr_en      = fb_wr_en_reg;
  assign fb_wr_addr    = fb_wr_addr_reg;
  assign fb_wr_data    = fb_wr_data_reg;
  assign busy          = busy_reg;
  assign frame_done    = frame_done_reg;
  assign overrun_count = overrun_reg;

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Bench for boid_frame_scheduler: a frame-level schedule model predicts every output on
// every cycle; directed frames pin the model with hand-computed addresses.
module tb_boid_frame_scheduler;
  localparam int N  = 4;
  localparam int FL = 3 * N + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         screenEnd = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   pos_index;
  logic [9:0]   pos_x;
  logic [8:0]   pos_y;
  logic         fb_wr_en;
  logic [19:0]  fb_wr_addr;
  logic         fb_wr_data;
  logic         busy;
  logic         frame_done;
  logic [7:0]   overrun_count;

  always #5 clk = ~clk;

  boid_frame_scheduler #(.NUM_BOIDS(N)) dut (
    .clk(clk), .reset(reset), .screenEnd(screenEnd), .enable(enable),
    .pos_index(pos_index), .pos_x(pos_x), .pos_y(pos_y),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .busy(busy), .frame_done(frame_done), .overrun_count(overrun_count)
  );

  // Boid position memory with one-cycle registered read.
  int mem_x [N];
  int mem_y [N];
  always @(posedge clk) begin
    pos_x <= 10'(mem_x[pos_index]);
    pos_y <= 9'(mem_y[pos_index]);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k is the cycle index within the current frame (0 = idle).
  int  m_k = 0;
  bit  m_se_d = 1'b0;
  int  m_ovr = 0;
  bit  m_pv [N];
  int  m_pa [N];
  bit  s_en   [FL+1];
  int  s_addr [FL+1];
  bit  s_data [FL+1];
  bit  m_start;
  bit  exp_en;

  int  rec_addr [$];
  bit  rec_data [$];
  int  busy_cycles = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_busy", busy, 0);
        check("rst_wr_en", fb_wr_en, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun_count, 0);
        check("rst_pos_index", pos_index, 0);
        check("rst_wr_addr", fb_wr_addr, 0);
        m_k = 0; m_se_d = 1'b0; m_ovr = 0;
        for (int i = 0; i < N; i++) begin m_pv[i] = 1'b0; m_pa[i] = 0; end
      end else begin
        exp_en = (m_k != 0) && s_en[m_k];
        check("busy", busy, (m_k != 0));
        check("frame_done", frame_done, (m_k == FL));
        check("wr_en", fb_wr_en, exp_en);
        check("overrun", overrun_count, m_ovr);
        if (exp_en) begin
          check("wr_addr", fb_wr_addr, s_addr[m_k]);
          check("wr_data", fb_wr_data, s_data[m_k]);
        end
        if (fb_wr_en) begin
          rec_addr.push_back(int'(fb_wr_addr));
          rec_data.push_back(fb_wr_data);
        end
        if (busy) busy_cycles++;
        // Advance to the upcoming rising edge.
        m_start = screenEnd && !m_se_d;
        m_se_d  = screenEnd;
        if (m_k != 0) begin
          if (m_start && m_ovr < 255) m_ovr++;
          m_k = (m_k == FL) ? 0 : m_k + 1;
        end else if (m_start && enable) begin
          for (int k = 0; k <= FL; k++) begin s_en[k] = 0; s_addr[k] = 0; s_data[k] = 0; end
          for (int i = 0; i < N; i++) begin
            if (m_pv[i]) begin s_en[i+2] = 1; s_addr[i+2] = m_pa[i]; s_data[i+2] = 0; end
          end
          for (int i = 0; i < N; i++) begin
            if (mem_x[i] < 640 && mem_y[i] < 480) begin
              m_pv[i] = 1; m_pa[i] = mem_x[i] + 640 * mem_y[i];
              s_en[N+3+2*i] = 1; s_addr[N+3+2*i] = m_pa[i]; s_data[N+3+2*i] = 1;
            end else begin
              m_pv[i] = 0;
            end
          end
          m_k = 1;
        end
      end
    end
  end

  task automatic pulse(input int w);
    @(posedge clk); #1 screenEnd = 1'b1;
    repeat (w) @(posedge clk);
    #1 screenEnd = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!frame_done && t < 200);
    check({tag, "_done_seen"}, frame_done, 1);
    repeat (2) @(posedge clk);
    #1;
    $display("frame %s: %0d writes, %0d busy cycles, overrun %0d", tag, rec_addr.size(), busy_cycles, overrun_count);
  endtask

  task automatic run_frame(input string tag, input bit extra);
    rec_addr.delete(); rec_data.delete(); busy_cycles = 0;
    pulse(1);
    if (extra) begin
      repeat (8) @(posedge clk);
      pulse(1);
    end
    wait_done(tag);
  endtask

  task automatic set_pos(input int i, input int x, input int y);
    mem_x[i] = x; mem_y[i] = y;
  endtask

  int e2_addr [8];
  int zeros;

  initial begin
    for (int i = 0; i < N; i++) begin mem_x[i] = 0; mem_y[i] = 0; end
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    busy_cycles = 0;
    repeat (5) @(posedge clk);
    #1 check("idle_busy_cycles", busy_cycles, 0);
    check("idle_no_writes", rec_addr.size(), 0);

    enable = 1'b1;
    set_pos(0, 0, 0); set_pos(1, 639, 479); set_pos(2, 10, 2); set_pos(3, 100, 50);
    run_frame("f1", 0);
    check("f1_writes", rec_addr.size(), 4);
    if (rec_addr.size() == 4) begin
      check("f1_a0", rec_addr[0], 0);
      check("f1_a1", rec_addr[1], 307199);
      check("f1_a2", rec_addr[2], 1290);
      check("f1_a3", rec_addr[3], 32100);
      for (int i = 0; i < 4; i++) check("f1_data", rec_data[i], 1);
    end
    check("f1_busy_cycles", busy_cycles, 13);
    check("model_pa1", m_pa[1], 307199);
    check("model_pa3", m_pa[3], 32100);

    set_pos(1, 1, 0);
    run_frame("f2", 0);
    e2_addr = '{0, 307199, 1290, 32100, 0, 1, 1290, 32100};
    check("f2_writes", rec_addr.size(), 8);
    if (rec_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("f2_addr", rec_addr[i], e2_addr[i]);
        check("f2_data", rec_data[i], (i >= 4));
      end
    end

    set_pos(2, 640, 5);
    run_frame("f3", 0);
    check("f3_writes", rec_addr.size(), 7);
    check("model_pv2", m_pv[2], 0);
    set_pos(2, 700, 479);
    run_frame("f4", 0);
    check("f4_writes", rec_addr.size(), 6);

    run_frame("ovr1", 1);
    check("ovr_one", overrun_count, 1);
    for (int r = 0; r < 300; r++) run_frame("ovr", 1);
    check("ovr_sat", overrun_count, 255);
    enable = 1'b0;
    busy_cycles = 0;
    pulse(1);
    repeat (20) @(posedge clk);
    #1 check("disabled_no_frame", busy_cycles, 0);
    check("disabled_ovr", overrun_count, 255);

    // Reset in the middle of the draw phase while a draw strobe is active.
    enable = 1'b1;
    pulse(1);
    repeat (8) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("midrst_wr_en", fb_wr_en, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    run_frame("post_rst", 0);
    zeros = 0;
    foreach (rec_data[i]) if (!rec_data[i]) zeros++;
    check("post_rst_no_erase", zeros, 0);
    check("post_rst_writes", rec_addr.size(), 3);

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) set_pos(i, $urandom_range(0, 700), $urandom_range(0, 511));
      enable = ($urandom_range(0, 4) != 0);
      rec_addr.delete(); rec_data.delete(); busy_cycles = 0;
      pulse($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) enable = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        pulse(1);
      end
      repeat (3 * N + 6) @(posedge clk);
      #1 $display("random frame %0d: %0d writes, %0d busy cycles", it, rec_addr.size(), busy_cycles);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
